writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and reset SHALL be synchronous and active-high.
REQ-002 Port clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port alu_valid  input  1  ALU result offered this cycle.
REQ-005 Port alu_rd  input  5  ALU destination register.
REQ-006 Port alu_data  input  32  ALU result value.
REQ-007 Port alu_ready  output  1  block can accept an ALU result this cycle.
REQ-008 Port ld_issue  input  1  a load has been issued; mark destination pending.
REQ-009 Port ld_issue_rd  input  5  destination of the issued load.
REQ-010 Port ld_valid  input  1  load data returned this cycle; always accepted, never stalled.
REQ-011 Port ld_rd  input  5  returned load destination.
REQ-012 Port ld_data  input  32  returned load value.
REQ-013 Ports rs1 and rs2  input  5 each  decode-stage source register indices for hazard query.
REQ-014 Ports rs1_busy and rs2_busy  output  1 each  source has a write not yet committed.
REQ-015 Port write  output  1  register-file write enable (registered).
REQ-016 Port rw  output  5  register-file write index (registered).
REQ-017 Port rwd  output  32  register-file write data (registered).
REQ-018 Port fifo_count  output  2  ALU holding-FIFO occupancy, 0..2.

Function
REQ-019 An ALU result SHALL be accepted only in a cycle with alu_valid=1 and alu_ready=1.
REQ-020 alu_ready SHALL be 1 exactly when fifo_count<2 and reset=0; it SHALL be derived from registered state only, with no path from alu_valid or ld_valid.
REQ-021 At each edge, a single commit SHALL be selected, in priority order: ld_valid, then FIFO head, then an ALU result accepted this cycle.
REQ-022 The selected commit SHALL appear on write/rw/rwd in the next cycle; latency SHALL be exactly 1 cycle from ld_valid, and 1 cycle from FIFO pop or ALU bypass.
REQ-023 An accepted ALU result not selected for commit SHALL be pushed to the FIFO tail in that cycle; FIFO order SHALL be strict FIFO.
REQ-024 In a cycle with no commit, write SHALL be 0; rw and rwd SHALL hold their previous values.
REQ-025 Any commit with destination 0 SHALL be consumed normally but SHALL drive write=0.
REQ-026 The FIFO SHALL accept a push and a pop in the same cycle; fifo_count SHALL change by push minus pop.
REQ-027 The FIFO SHALL never overflow, and a pop from an empty FIFO SHALL never occur.
REQ-028 The scoreboard SHALL hold busy bits for registers 1..31.
REQ-029 ld_issue SHALL set busy[ld_issue_rd]; an index of 0 SHALL be ignored.
REQ-030 ld_valid SHALL clear busy[ld_rd] at the same edge that captures the commit.
REQ-031 If a set and a clear target the same register in one cycle, the set SHALL win.
REQ-032 ld_valid SHALL commit regardless of the busy state.
REQ-033 rsN_busy SHALL be combinational and SHALL equal: (rsN != 0) and (busy[rsN], or any valid FIFO entry with rd == rsN, or the current registered commit with write=1 and rw == rsN).
REQ-034 The registered commit term in REQ-033 SHALL cover the cycle in which the register file is written.

Reset
REQ-035 While reset=1: write=0, rw=0, rwd=0, fifo_count=0, alu_ready=0, rs1_busy=0, rs2_busy=0.
REQ-036 While reset=1, all busy bits and FIFO entries SHALL be cleared, and all inputs SHALL be ignored.
REQ-037 Reset asserted mid-operation SHALL discard buffered ALU results without writing them.
REQ-038 In the first cycle after reset deasserts, alu_ready SHALL be 1.

Verification
REQ-039 Bench SHALL drive ALU rd=5 data=0x11 alone -> next cycle write=1, rw=5, rwd=0x11, fifo_count=0.
REQ-040 Bench SHALL drive ld rd=3 0xAA and ALU rd=4 0xBB in the same cycle -> cycle+1 writes r3=0xAA with fifo_count=1; cycle+2 writes r4=0xBB with fifo_count=0.
REQ-041 Bench SHALL drive ld_valid for 3 consecutive cycles while ALU offers every cycle -> fifo_count reaches 2, alu_ready=0, no result lost, and ALU results drain in order after the loads.
REQ-042 Bench SHALL issue a load to rd=7 and query rs1=7 -> rs1_busy=1 until the cycle of the write of r7, and 0 after it.
REQ-043 Bench SHALL drive ld_issue rd=9 with ld_valid rd=9 in the same cycle -> busy[9] stays set, and r9 is written once.
REQ-044 Bench SHALL fill the FIFO to 2 entries and then assert reset -> no write occurs, fifo_count=0, and alu_ready=1 after reset deasserts.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates load returns and ALU results onto one
// register-file write port, with a 2-deep ALU holding FIFO and busy scoreboard.
`timescale 1ns/1ps
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        write,
  output logic [4:0]  rw,
  output logic [31:0] rwd,
  output logic [1:0]  fifo_count
);

  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic [4:0]  q_rd [2];
  logic [31:0] q_data [2];
  logic [4:0]  q_rd_nxt [2];
  logic [31:0] q_data_nxt [2];
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic [1:0]  count_pop;

  logic        accept;
  logic        has_head;
  logic        sel_ld;
  logic        sel_fifo;
  logic        sel_alu;
  logic        commit;
  logic        push;
  logic        pop;
  logic [4:0]  c_rd;
  logic [31:0] c_data;

  // ready looks only at registered occupancy, never at this cycle's valids
  assign alu_ready  = ~reset & (count < 2'd2);
  assign fifo_count = count;

  always_comb begin
    accept   = alu_valid & alu_ready;
    has_head = count != 2'd0;
    sel_ld   = ld_valid;
    sel_fifo = ~ld_valid & has_head;
    sel_alu  = ~ld_valid & ~has_head & accept;
    commit   = sel_ld | sel_fifo | sel_alu;
    pop      = sel_fifo;
    push     = accept & ~sel_alu;
  end

  always_comb begin
    c_rd   = 5'd0;
    c_data = 32'd0;
    unique case (1'b1)
      sel_ld: begin
        c_rd   = ld_rd;
        c_data = ld_data;
      end
      sel_fifo: begin
        c_rd   = q_rd[0];
        c_data = q_data[0];
      end
      sel_alu: begin
        c_rd   = alu_rd;
        c_data = alu_data;
      end
      default: begin
        c_rd   = 5'd0;
        c_data = 32'd0;
      end
    endcase
  end

  always_comb begin
    q_rd_nxt[0]   = q_rd[0];
    q_rd_nxt[1]   = q_rd[1];
    q_data_nxt[0] = q_data[0];
    q_data_nxt[1] = q_data[1];
    count_pop     = count - {1'b0, pop};
    if (pop) begin
      q_rd_nxt[0]   = q_rd[1];
      q_data_nxt[0] = q_data[1];
    end
    // push only happens with count<2, so the tail slot is 0 or 1
    if (push) begin
      q_rd_nxt[count_pop[0]]   = alu_rd;
      q_data_nxt[count_pop[0]] = alu_data;
    end
    count_nxt = count_pop + {1'b0, push};
  end

  always_comb begin
    busy_nxt = busy;
    if (ld_valid)
      busy_nxt[ld_rd] = 1'b0;
    if (ld_issue)
      busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= '0;
      count     <= 2'd0;
      q_rd[0]   <= 5'd0;
      q_rd[1]   <= 5'd0;
      q_data[0] <= 32'd0;
      q_data[1] <= 32'd0;
      write     <= 1'b0;
      rw        <= 5'd0;
      rwd       <= 32'd0;
    end else begin
      busy      <= busy_nxt;
      count     <= count_nxt;
      q_rd[0]   <= q_rd_nxt[0];
      q_rd[1]   <= q_rd_nxt[1];
      q_data[0] <= q_data_nxt[0];
      q_data[1] <= q_data_nxt[1];
      write     <= commit & (c_rd != 5'd0);
      if (commit) begin
        rw  <= c_rd;
        rwd <= c_data;
      end
    end
  end

  // the registered-commit term covers the cycle the regfile is written
  assign rs1_busy = ~reset & (rs1 != 5'd0) &
    (busy[rs1] |
     ((count != 2'd0) & (q_rd[0] == rs1)) |
     ((count == 2'd2) & (q_rd[1] == rs1)) |
     (write & (rw == rs1)));

  assign rs2_busy = ~reset & (rs2 != 5'd0) &
    (busy[rs2] |
     ((count != 2'd0) & (q_rd[0] == rs2)) |
     ((count == 2'd2) & (q_rd[1] == rs2)) |
     (write & (rw == rs2)));

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed vectors push expected
// writes; a negedge monitor pops and compares each register-file write.
`timescale 1ns/1ps
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        write;
  logic [4:0]  rw;
  logic [31:0] rwd;
  logic [1:0]  fifo_count;

  int compared = 0;
  int mismatched = 0;
  logic [36:0] sb [$];

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write(write), .rw(rw), .rwd(rwd),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] r,
                          input logic [31:0] d);
    sb.push_back({r, d});
  endtask

  // monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    logic [36:0] e;
    if (write === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL wb_unexpected: got write rw=%0d rwd=%0h expected none",
                 rw, rwd);
      end else begin
        e = sb.pop_front();
        chk("wb_rw", {27'd0, rw}, {27'd0, e[36:32]});
        chk("wb_rwd", rwd, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_issue_rd = 5'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    rs1 = 5'd5; rs2 = 5'd0;
    repeat (3) tick();
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_rw", {27'd0, rw}, 32'd0);
    chk("rst_rwd", rwd, 32'd0);
    chk("rst_count", {30'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, alu_ready}, 32'd1);

    // ALU alone: bypass straight to the write port
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    push_exp(5'd5, 32'h11);
    tick();
    alu_valid = 1'b0;
    chk("bypass_count", {30'd0, fifo_count}, 32'd0);
    chk("bypass_write", {31'd0, write}, 32'd1);
    tick();

    // load and ALU together: load first, ALU next cycle
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hAA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB;
    push_exp(5'd3, 32'hAA);
    push_exp(5'd4, 32'hBB);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("pair_count1", {30'd0, fifo_count}, 32'd1);
    tick();
    chk("pair_count0", {30'd0, fifo_count}, 32'd0);
    tick();

    // three loads back to back while the ALU keeps offering
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h100;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h200;
    push_exp(5'd10, 32'h100);
    tick();
    chk("burst_count1", {30'd0, fifo_count}, 32'd1);
    ld_rd = 5'd12; ld_data = 32'h101;
    alu_rd = 5'd13; alu_data = 32'h201;
    push_exp(5'd12, 32'h101);
    tick();
    chk("burst_count2", {30'd0, fifo_count}, 32'd2);
    chk("burst_ready0", {31'd0, alu_ready}, 32'd0);
    rs2 = 5'd11;
    #1;
    chk("fifo_hazard", {31'd0, rs2_busy}, 32'd1);
    ld_rd = 5'd14; ld_data = 32'h102;
    alu_rd = 5'd15; alu_data = 32'h202;
    push_exp(5'd14, 32'h102);
    push_exp(5'd11, 32'h200);
    push_exp(5'd13, 32'h201);
    tick();
    ld_valid = 1'b0;
    chk("burst_full", {30'd0, fifo_count}, 32'd2);
    chk("burst_stall", {31'd0, alu_ready}, 32'd0);
    tick();
    chk("drain_count1", {30'd0, fifo_count}, 32'd1);
    chk("drain_ready1", {31'd0, alu_ready}, 32'd1);
    push_exp(5'd15, 32'h202);
    tick();
    alu_valid = 1'b0;
    chk("drain_pushpop", {30'd0, fifo_count}, 32'd1);
    tick();
    chk("drain_empty", {30'd0, fifo_count}, 32'd0);
    rs2 = 5'd0;
    tick();

    // load scoreboard: r7 busy until its write cycle
    ld_issue = 1'b1; ld_issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd8;
    tick();
    ld_issue = 1'b0;
    chk("r7_busy_a", {31'd0, rs1_busy}, 32'd1);
    chk("r8_clear", {31'd0, rs2_busy}, 32'd0);
    tick();
    chk("r7_busy_b", {31'd0, rs1_busy}, 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    push_exp(5'd7, 32'h77);
    tick();
    ld_valid = 1'b0;
    chk("r7_busy_wr", {31'd0, rs1_busy}, 32'd1);
    tick();
    chk("r7_free", {31'd0, rs1_busy}, 32'd0);

    // set and clear of r9 in the same cycle: set wins
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    rs1 = 5'd9;
    push_exp(5'd9, 32'h99);
    tick();
    ld_issue = 1'b0; ld_valid = 1'b0;
    chk("r9_busy_wr", {31'd0, rs1_busy}, 32'd1);
    tick();
    chk("r9_busy_held", {31'd0, rs1_busy}, 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A;
    push_exp(5'd9, 32'h9A);
    tick();
    ld_valid = 1'b0;
    tick();
    chk("r9_free", {31'd0, rs1_busy}, 32'd0);

    // fill the FIFO, then reset discards it
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
    push_exp(5'd1, 32'h1);
    tick();
    ld_rd = 5'd16; ld_data = 32'h3;
    alu_rd = 5'd17; alu_data = 32'h4;
    push_exp(5'd16, 32'h3);
    tick();
    chk("fill_count", {30'd0, fifo_count}, 32'd2);
    rs1 = 5'd17;
    #1;
    chk("fill_hazard", {31'd0, rs1_busy}, 32'd1);
    reset = 1'b1;
    ld_rd = 5'd20; ld_data = 32'hDEAD;
    alu_rd = 5'd21; alu_data = 32'hBEEF;
    tick();
    chk("mid_rst_write", {31'd0, write}, 32'd0);
    chk("mid_rst_count", {30'd0, fifo_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, alu_ready}, 32'd1);
    chk("post_rst_count", {30'd0, fifo_count}, 32'd0);
    chk("post_rst_hazard", {31'd0, rs1_busy}, 32'd0);
    repeat (4) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
